// File: rtl/control_unit_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, ALU codes,
// sequencer states and the instruction-class decode used by the FSM.
package cpu_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHL  = 5'b01000;
    localparam logic [4:0] OP_ADDI = 5'b01001;
    localparam logic [4:0] OP_ANDI = 5'b01010;
    localparam logic [4:0] OP_ORI  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01100;
    localparam logic [4:0] OP_DIV  = 5'b01101;
    localparam logic [4:0] OP_MFHI = 5'b10110;
    localparam logic [4:0] OP_MFLO = 5'b10111;
    localparam logic [4:0] OP_NOP  = 5'b11000;
    localparam logic [4:0] OP_HALT = 5'b11001;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_SHR = 4'b0100;
    localparam logic [3:0] ALU_SHL = 4'b0101;
    localparam logic [3:0] ALU_MUL = 4'b0110;
    localparam logic [3:0] ALU_DIV = 4'b0111;

    typedef enum logic [3:0] {
        RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT
    } state_t;

    typedef enum logic [2:0] {
        IC_ALU, IC_IMM, IC_MULDIV, IC_LD, IC_ST, IC_MOVE, IC_NOP, IC_HALT
    } iclass_t;

    function automatic iclass_t decode_class(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL: return IC_ALU;
            OP_ADDI, OP_ANDI, OP_ORI:                      return IC_IMM;
            OP_MUL, OP_DIV:                                return IC_MULDIV;
            OP_LD:                                         return IC_LD;
            OP_ST:                                         return IC_ST;
            OP_MFHI, OP_MFLO:                              return IC_MOVE;
            OP_HALT:                                       return IC_HALT;
            default:                                       return IC_NOP;
        endcase
    endfunction

    function automatic logic [3:0] alu_code(input logic [4:0] op);
        case (op)
            OP_SUB:          return ALU_SUB;
            OP_AND, OP_ANDI: return ALU_AND;
            OP_OR, OP_ORI:   return ALU_OR;
            OP_SHR:          return ALU_SHR;
            OP_SHL:          return ALU_SHL;
            OP_MUL:          return ALU_MUL;
            OP_DIV:          return ALU_DIV;
            default:         return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Strobe bundle between the control sequencer (master) and the CPU datapath (slave).
interface control_unit_if;
    logic [31:0] IR;
    logic        Stop;
    logic        Run;
    logic        PCout, Zlowout, Zhighout, HIout, LOout, MDRout, In_Portout, Cout;
    logic        MARin, PCin, MDRin, IRin, Yin, HIin, LOin, Zin_low, Zin_high;
    logic        IncPC, Read, Write;
    logic [3:0]  operation;
    logic [15:0] Rin_vec;
    logic [15:0] Rout_vec;

    modport master (
        input  IR, Stop,
        output Run, PCout, Zlowout, Zhighout, HIout, LOout, MDRout, In_Portout, Cout,
        output MARin, PCin, MDRin, IRin, Yin, HIin, LOin, Zin_low, Zin_high,
        output IncPC, Read, Write, operation, Rin_vec, Rout_vec
    );

    modport slave (
        output IR, Stop,
        input  Run, PCout, Zlowout, Zhighout, HIout, LOout, MDRout, In_Portout, Cout,
        input  MARin, PCin, MDRin, IRin, Yin, HIin, LOin, Zin_low, Zin_high,
        input  IncPC, Read, Write, operation, Rin_vec, Rout_vec
    );
endinterface

// File: rtl/control_unit_select_encode.sv
// General-register select/encode: picks ra/rb/rc from IR and turns the
// Rin/Rout/BAout strobes into one-hot register enables.
module select_encode (
    input  logic [11:0] ir_regs,
    input  logic        gra,
    input  logic        grb,
    input  logic        grc,
    input  logic        rin,
    input  logic        rout,
    input  logic        baout,
    output logic [15:0] rin_vec,
    output logic [15:0] rout_vec
);
    logic [3:0]  index;
    logic [15:0] onehot;

    always_comb begin
        index = 4'd0;
        if (gra)
            index = ir_regs[11:8];
        else if (grb)
            index = ir_regs[7:4];
        else if (grc)
            index = ir_regs[3:0];
    end

    assign onehot  = 16'h0001 << index;
    assign rin_vec = rin ? onehot : 16'h0000;

    // Base-address reads of R0 must put zero on the bus, not R0's contents.
    assign rout_vec = (rout || (baout && (index != 4'd0))) ? onehot : 16'h0000;

endmodule

// File: rtl/control_unit.sv
// Hardwired multi-cycle control sequencer: fetch T0-T2, execute T3-T7 decoded
// from the IR opcode; drives every datapath strobe as a Moore function of state/IR.
//
// state | meaning
// RST   | held in reset, every output low
// T0    | PC to MAR, PC+1 into Z
// T1    | Z to PC, memory read into MDR
// T2    | MDR to IR
// T3-T7 | execute steps, length depends on opcode class
// HALT  | stopped, only clear leaves
module control_unit
    import cpu_pkg::*;
(
    input  logic           Clock,
    input  logic           clear,
    control_unit_if.master cu
);
    state_t  state, state_nxt;
    iclass_t icls;
    logic    instr_last;
    logic    gra, grb, grc, rin, rout, baout;
    logic    unused_ir;

    assign icls      = decode_class(cu.IR[31:27]);
    assign unused_ir = ^cu.IR[14:0];

    always_ff @(posedge Clock) begin
        if (clear)
            state <= RST;
        else
            state <= state_nxt;
    end

    always_comb begin
        instr_last = 1'b0;
        case (state)
            T3:      instr_last = (icls == IC_MOVE) || (icls == IC_NOP);
            T5:      instr_last = (icls == IC_ALU) || (icls == IC_IMM);
            T6:      instr_last = (icls == IC_MULDIV);
            T7:      instr_last = 1'b1;
            default: instr_last = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RST:     state_nxt = T0;
            T0:      state_nxt = T1;
            T1:      state_nxt = T2;
            T2:      state_nxt = T3;
            T3:      state_nxt = (icls == IC_HALT) ? HALT : T4;
            T4:      state_nxt = T5;
            T5:      state_nxt = T6;
            T6:      state_nxt = T7;
            T7:      state_nxt = T0;
            HALT:    state_nxt = HALT;
            default: state_nxt = RST;
        endcase
        if (instr_last)
            state_nxt = cu.Stop ? HALT : T0;
    end

    always_comb begin
        cu.Run        = (state != RST) && (state != HALT);
        cu.PCout      = 1'b0;
        cu.Zlowout    = 1'b0;
        cu.Zhighout   = 1'b0;
        cu.HIout      = 1'b0;
        cu.LOout      = 1'b0;
        cu.MDRout     = 1'b0;
        cu.In_Portout = 1'b0;
        cu.Cout       = 1'b0;
        cu.MARin      = 1'b0;
        cu.PCin       = 1'b0;
        cu.MDRin      = 1'b0;
        cu.IRin       = 1'b0;
        cu.Yin        = 1'b0;
        cu.HIin       = 1'b0;
        cu.LOin       = 1'b0;
        cu.Zin_low    = 1'b0;
        cu.Zin_high   = 1'b0;
        cu.IncPC      = 1'b0;
        cu.Read       = 1'b0;
        cu.Write      = 1'b0;
        cu.operation  = ALU_ADD;
        gra           = 1'b0;
        grb           = 1'b0;
        grc           = 1'b0;
        rin           = 1'b0;
        rout          = 1'b0;
        baout         = 1'b0;

        case (state)
            T0: begin
                cu.PCout   = 1'b1;
                cu.MARin   = 1'b1;
                cu.IncPC   = 1'b1;
                cu.Zin_low = 1'b1;
            end
            T1: begin
                cu.Zlowout = 1'b1;
                cu.PCin    = 1'b1;
                cu.Read    = 1'b1;
                cu.MDRin   = 1'b1;
            end
            T2: begin
                cu.MDRout = 1'b1;
                cu.IRin   = 1'b1;
            end
            T3: begin
                case (icls)
                    IC_ALU, IC_IMM: begin grb = 1'b1; rout = 1'b1; cu.Yin = 1'b1; end
                    IC_MULDIV:      begin gra = 1'b1; rout = 1'b1; cu.Yin = 1'b1; end
                    IC_LD, IC_ST:   begin grb = 1'b1; baout = 1'b1; cu.Yin = 1'b1; end
                    IC_MOVE: begin
                        cu.HIout = (cu.IR[31:27] == OP_MFHI);
                        cu.LOout = (cu.IR[31:27] == OP_MFLO);
                        gra      = 1'b1;
                        rin      = 1'b1;
                    end
                    default: ;
                endcase
            end
            T4: begin
                case (icls)
                    IC_ALU: begin
                        grc          = 1'b1;
                        rout         = 1'b1;
                        cu.operation = alu_code(cu.IR[31:27]);
                        cu.Zin_low   = 1'b1;
                    end
                    IC_IMM: begin
                        cu.Cout      = 1'b1;
                        cu.operation = alu_code(cu.IR[31:27]);
                        cu.Zin_low   = 1'b1;
                    end
                    IC_MULDIV: begin
                        grb          = 1'b1;
                        rout         = 1'b1;
                        cu.operation = alu_code(cu.IR[31:27]);
                        cu.Zin_low   = 1'b1;
                        cu.Zin_high  = 1'b1;
                    end
                    IC_LD, IC_ST: begin cu.Cout = 1'b1; cu.Zin_low = 1'b1; end
                    default: ;
                endcase
            end
            T5: begin
                case (icls)
                    IC_ALU, IC_IMM: begin cu.Zlowout = 1'b1; gra = 1'b1; rin = 1'b1; end
                    IC_MULDIV:      begin cu.Zlowout = 1'b1; cu.LOin = 1'b1; end
                    IC_LD, IC_ST:   begin cu.Zlowout = 1'b1; cu.MARin = 1'b1; end
                    default: ;
                endcase
            end
            T6: begin
                case (icls)
                    IC_MULDIV: begin cu.Zhighout = 1'b1; cu.HIin = 1'b1; end
                    IC_LD:     begin cu.Read = 1'b1; cu.MDRin = 1'b1; end
                    IC_ST:     begin gra = 1'b1; rout = 1'b1; cu.MDRin = 1'b1; end
                    default: ;
                endcase
            end
            T7: begin
                case (icls)
                    IC_LD:   begin cu.MDRout = 1'b1; gra = 1'b1; rin = 1'b1; end
                    IC_ST:   cu.Write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    select_encode u_select_encode (
        .ir_regs  (cu.IR[26:15]),
        .gra      (gra),
        .grb      (grb),
        .grc      (grc),
        .rin      (rin),
        .rout     (rout),
        .baout    (baout),
        .rin_vec  (cu.Rin_vec),
        .rout_vec (cu.Rout_vec)
    );

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-cycle comparison against an
// instruction-level step model, plus directed literal checks.
module tb_control_unit;

    typedef struct packed {
        logic run, pcout, zlowout, zhighout, hiout, loout, mdrout, inportout, cout;
        logic marin, pcin, mdrin, irin, yin, hiin, loin, zin_low, zin_high, incpc, read, write;
        logic [3:0]  op;
        logic [15:0] rin;
        logic [15:0] rout;
    } outs_t;

    logic Clock;
    logic clear;
    int   errors = 0;
    int   checks = 0;
    int   wcount = 0;
    int   hilo_seen = 0;
    bit   cmp_en = 0;

    control_unit_if bus ();

    control_unit dut (
        .Clock (Clock),
        .clear (clear),
        .cu    (bus)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    outs_t dut_o;
    assign dut_o = {bus.Run, bus.PCout, bus.Zlowout, bus.Zhighout, bus.HIout, bus.LOout,
                    bus.MDRout, bus.In_Portout, bus.Cout, bus.MARin, bus.PCin, bus.MDRin,
                    bus.IRin, bus.Yin, bus.HIin, bus.LOin, bus.Zin_low, bus.Zin_high,
                    bus.IncPC, bus.Read, bus.Write, bus.operation, bus.Rin_vec, bus.Rout_vec};

    // Instruction-level model: mode 0 = reset, 1 = sequencing, 2 = halted.
    int m_mode = 0;
    int m_step = 0;

    function automatic int cycles_of(input logic [4:0] opc);
        if (opc >= 5'd3 && opc <= 5'd11) return 6;
        if (opc == 5'd12 || opc == 5'd13) return 7;
        if (opc == 5'd0 || opc == 5'd2)   return 8;
        return 4;
    endfunction

    function automatic logic [3:0] op_of(input logic [4:0] opc);
        logic [3:0] tbl [0:13];
        tbl = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0, 4'd2, 4'd3, 4'd6, 4'd7};
        return (opc <= 5'd13) ? tbl[opc] : 4'd0;
    endfunction

    function automatic outs_t expect_step(input int step, input logic [31:0] ir);
        outs_t o;
        logic [4:0] opc;
        logic [15:0] ra1, rb1, rc1;
        bit alu, imm, md, ld, st;
        o   = '0;
        opc = ir[31:27];
        ra1 = 16'h0001 << ir[26:23];
        rb1 = 16'h0001 << ir[22:19];
        rc1 = 16'h0001 << ir[18:15];
        alu = (opc >= 5'd3 && opc <= 5'd8);
        imm = (opc >= 5'd9 && opc <= 5'd11);
        md  = (opc == 5'd12 || opc == 5'd13);
        ld  = (opc == 5'd0);
        st  = (opc == 5'd2);
        o.run = 1'b1;
        case (step)
            0: begin o.pcout = 1; o.marin = 1; o.incpc = 1; o.zin_low = 1; end
            1: begin o.zlowout = 1; o.pcin = 1; o.read = 1; o.mdrin = 1; end
            2: begin o.mdrout = 1; o.irin = 1; end
            3: begin
                if (alu || imm)  begin o.rout = rb1; o.yin = 1; end
                else if (md)     begin o.rout = ra1; o.yin = 1; end
                else if (ld || st) begin o.rout = (ir[22:19] == 4'd0) ? 16'h0 : rb1; o.yin = 1; end
                else if (opc == 5'd22) begin o.hiout = 1; o.rin = ra1; end
                else if (opc == 5'd23) begin o.loout = 1; o.rin = ra1; end
            end
            4: begin
                if (alu)         begin o.rout = rc1; o.op = op_of(opc); o.zin_low = 1; end
                else if (imm)    begin o.cout = 1; o.op = op_of(opc); o.zin_low = 1; end
                else if (md)     begin o.rout = rb1; o.op = op_of(opc); o.zin_low = 1; o.zin_high = 1; end
                else if (ld || st) begin o.cout = 1; o.zin_low = 1; end
            end
            5: begin
                if (alu || imm)  begin o.zlowout = 1; o.rin = ra1; end
                else if (md)     begin o.zlowout = 1; o.loin = 1; end
                else if (ld || st) begin o.zlowout = 1; o.marin = 1; end
            end
            6: begin
                if (md)      begin o.zhighout = 1; o.hiin = 1; end
                else if (ld) begin o.read = 1; o.mdrin = 1; end
                else if (st) begin o.rout = ra1; o.mdrin = 1; end
            end
            7: begin
                if (ld)      begin o.mdrout = 1; o.rin = ra1; end
                else if (st) o.write = 1;
            end
            default: ;
        endcase
        return o;
    endfunction

    always @(posedge Clock) begin
        if (clear)
            m_mode <= 0;
        else if (m_mode == 0) begin
            m_mode <= 1;
            m_step <= 0;
        end else if (m_mode == 1) begin
            if (m_step == cycles_of(bus.IR[31:27]) - 1) begin
                if (bus.IR[31:27] == 5'd25 || bus.Stop)
                    m_mode <= 2;
                else
                    m_step <= 0;
            end else
                m_step <= m_step + 1;
        end
    end

    always @(negedge Clock) begin
        outs_t exp_o;
        if (cmp_en) begin
            exp_o = (m_mode == 1) ? expect_step(m_step, bus.IR) : '0;
            checks++;
            if (dut_o !== exp_o) begin
                errors++;
                $display("FAIL cycle_model t=%0t mode=%0d step=%0d dut=%h model=%h",
                         $time, m_mode, m_step, dut_o, exp_o);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #2;
        if (bus.Write) wcount++;
        if (bus.HIin || bus.LOin) hilo_seen++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        clear    = 1'b1;
        bus.Stop = 1'b0;
        bus.IR   = 32'h0;
        steps(2);
        cmp_en = 1;
        chk("reset_all_zero", 64'(dut_o), 64'h0);

        // add r2,r3,r4
        clear  = 1'b0;
        bus.IR = 32'h191A0000;
        step();
        chk("add_t0_pcout", 64'(bus.PCout), 64'h1);
        chk("add_t0_incpc", 64'(bus.IncPC), 64'h1);
        steps(3);
        chk("add_t3_rout", 64'(bus.Rout_vec), 64'h0008);
        chk("add_t3_yin", 64'(bus.Yin), 64'h1);
        step();
        chk("add_t4_rout", 64'(bus.Rout_vec), 64'h0010);
        chk("add_t4_op", 64'(bus.operation), 64'h0);
        step();
        chk("add_t5_rin", 64'(bus.Rin_vec), 64'h0004);
        step();
        chk("add_back_t0", 64'(bus.PCout), 64'h1);

        // ld r1, 0x55(r0)
        bus.IR = 32'h00800055;
        steps(3);
        chk("ld_t3_ba_zero", 64'(bus.Rout_vec), 64'h0);
        steps(3);
        chk("ld_t6_read", 64'({bus.Read, bus.MDRin}), 64'h3);
        step();
        chk("ld_t7_rin", 64'(bus.Rin_vec), 64'h0002);
        step();
        chk("ld_back_t0", 64'(bus.PCout), 64'h1);

        // st r5, 0x10(r2)
        bus.IR = 32'h12900010;
        wcount = 0;
        steps(3);
        chk("st_t3_ba_r2", 64'(bus.Rout_vec), 64'h0004);
        steps(3);
        chk("st_t6_rout", 64'(bus.Rout_vec), 64'h0020);
        chk("st_t6_read", 64'({bus.Read, bus.MDRin}), 64'h1);
        step();
        chk("st_t7_write", 64'({bus.Write, bus.Read}), 64'h2);
        step();
        chk("st_write_count", 64'(wcount), 64'h1);

        // mul r6,r7
        bus.IR = 32'h63380000;
        steps(3);
        chk("mul_t3_rout", 64'(bus.Rout_vec), 64'h0040);
        step();
        chk("mul_t4_zin", 64'({bus.Zin_low, bus.Zin_high}), 64'h3);
        chk("mul_t4_op", 64'(bus.operation), 64'h6);
        step();
        chk("mul_t5_loin", 64'({bus.LOin, bus.operation}), 64'h10);
        step();
        chk("mul_t6_hiin", 64'(bus.HIin), 64'h1);
        step();

        // mfhi r9
        bus.IR = 32'hB4800000;
        steps(3);
        chk("mfhi_t3", 64'({bus.HIout, bus.Rin_vec}), 64'h10200);
        step();
        chk("mfhi_back_t0", 64'(bus.PCout), 64'h1);

        // sub r1,r2,r3 ; addi r2,r3,7 ; undefined opcode
        bus.IR = 32'h20918000;
        steps(4);
        chk("sub_t4", 64'({bus.operation, bus.Rout_vec}), 64'h10008);
        steps(2);
        bus.IR = 32'h49180007;
        steps(4);
        chk("addi_t4", 64'({bus.Cout, bus.Rout_vec}), 64'h10000);
        steps(2);
        bus.IR = 32'hF8000000;
        steps(4);
        chk("undef_back_t0", 64'(bus.PCout), 64'h1);

        // Stop pulse mid-fetch is ignored; held through final state halts
        bus.IR = 32'h191A0000;
        steps(2);
        bus.Stop = 1'b1;
        step();
        bus.Stop = 1'b0;
        steps(3);
        chk("stop_pulse_ignored", 64'(bus.PCout), 64'h1);
        steps(3);
        bus.Stop = 1'b1;
        steps(3);
        chk("halt_run_low", 64'(bus.Run), 64'h0);
        bus.Stop = 1'b0;
        steps(20);
        chk("halt_held", 64'(dut_o), 64'h0);
        clear = 1'b1;
        step();
        clear = 1'b0;
        step();
        chk("halt_clear_t0", 64'(bus.PCout), 64'h1);

        // div aborted by clear in T4
        bus.IR    = 32'h6A280000;
        hilo_seen = 0;
        steps(4);
        chk("div_t4_op", 64'(bus.operation), 64'h7);
        clear = 1'b1;
        step();
        chk("div_abort_rst", 64'(dut_o), 64'h0);
        clear = 1'b0;
        step();
        chk("div_abort_t0", 64'(bus.PCout), 64'h1);
        chk("div_no_hilo", 64'(hilo_seen), 64'h0);

        // halt instruction
        bus.IR = 32'hC8000000;
        steps(4);
        chk("halt_instr", 64'(bus.Run), 64'h0);
        steps(3);

        cmp_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
